pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
//
// PURPOSE
//   Parametrised, pipelined two's-complement adder/subtractor. It is the
//   clocked successor to the combinational 64-bit ripple-carry adder.
//   The WIDTH-bit operation is split into SEG-bit ripple segments, one
//   segment per pipeline stage. The carry is registered between stages, so
//   the block sustains one operation per clock at high fmax. It sits in the
//   datapath behind a valid/ready stream and provides carry and signed
//   overflow flags.
//
// PARAMETERS
//   WIDTH   64  operand/result width in bits; WIDTH % SEG must be 0
//   SEG     16  bits added per stage; STAGES = WIDTH/SEG is the latency
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      a/b/cin/sub hold a valid operation
//   in_ready   out  1      block accepts an operation this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add only)
//   sub        in   1      1: s = a - b ; 0: s = a + b + cin
//   out_valid  out  1      s/cout/ovf hold a valid result
//   out_ready  in   1      downstream accepts the result this cycle
//   s          out  WIDTH  result
//   cout       out  1      carry out of the MSB (when sub=1, 1 means no borrow)
//   ovf        out  1      signed overflow of the result
//
// BEHAVIOUR
//   - Operation: s = a + (sub ? ~b : b) + (sub ? 1 : cin), taken mod 2^WIDTH.
//     When sub=1, cin is ignored.
//   - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff is the
//     possibly inverted B.
//   - Stage k (k = 0..STAGES-1):
//       * adds segment k of a and b_eff plus the registered carry from
//         stage k-1 (stage 0 uses the effective carry-in);
//       * higher segments travel through skew registers;
//       * completed lower result segments travel through deskew registers.
//   - Global advance: adv = !out_valid || out_ready. in_ready = adv.
//     - All stage registers, including the valid bits, load only when adv=1.
//     - When adv=0 every stage holds its contents.
//   - Transfers: an input transfer occurs when in_valid && in_ready. An
//     output transfer occurs when out_valid && out_ready.
//   - Latency: a result appears on out_valid exactly STAGES cycles after
//     its input transfer, provided there are no stalls. Each stall cycle
//     adds one cycle.
//   - Throughput: one operation per cycle while out_ready=1.
//   - Bubbles: when in_valid=0 and adv=1, an invalid slot enters the
//     pipeline and flows through. It never asserts out_valid.
//   - Outputs are registered. s, cout and ovf remain stable while
//     out_valid && !out_ready.
//   - Ordering: results leave in input order. No operation is dropped or
//     duplicated.
//   - Reset: asynchronous. While rst is high:
//       * every valid bit, carry and data register is 0;
//       * out_valid=0, s=0, cout=0, ovf=0.
//     in_ready reads 1 once out_valid=0, and it is also 1 during reset.
//     Any operation in flight is discarded. The first input after rst
//     falls behaves exactly as the first input after power-up.
//   - Boundaries:
//       * full-width carry chain (all-ones + 1) propagates through every stage;
//       * -MIN via sub=1 with a=0, b=MIN gives s=MIN and ovf=1;
//       * in_valid and stall in the same cycle: input is not taken;
//         the source must hold it.
//
// TESTING
//   1. a=-5, b=-1, cin=0, sub=0
//      -> after 4 cycles: s=64'hFFFF_FFFF_FFFF_FFFA, cout=1, ovf=0.
//   2. a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1
//      -> s=0, cout=1, ovf=0; carry crosses all 4 stages.
//   3. a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0
//      -> s=64'h8000_0000_0000_0000, cout=0, ovf=1.
//   4. a=3, b=5, sub=1, cin=1 (ignored)
//      -> s=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//   5. Stream 8 ops back-to-back; hold out_ready=0 for 3 cycles mid-stream
//      -> in_ready=0 during the stall, outputs stay stable, all 8 results
//         arrive in order and match the reference model.
//   6. Assert rst for 1 cycle with 3 ops in flight
//      -> out_valid=0 and s=0 immediately; no stale result appears later;
//         the next op completes 4 cycles after its input transfer.
//      Also run scenarios 1 and 5 with WIDTH=32, SEG=8.

Source files
------------

// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub_if
//  Description : Valid/ready operand stream in, valid/ready result stream out,
//                for the pipelined adder/subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    // Source of operands / sink of results
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    // The arithmetic block itself
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub
//  Description : Pipelined two's-complement adder/subtractor. One SEG-bit
//                ripple segment per stage, carry registered between stages,
//                operands skewed forward and finished segments deskewed.
//                Latency WIDTH/SEG cycles, one operation per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_addsub_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;

    // Per-stage pipeline registers. Operands are stored full width; later
    // stages only consume their own segment and above.
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];
    logic             r_ovf;

    // Next-state values produced by each stage's segment adder
    logic [WIDTH-1:0] w_a_nxt [STAGES];
    logic [WIDTH-1:0] w_b_nxt [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_nxt [STAGES];
    logic             w_v_nxt [STAGES];
    logic             w_ovf_nxt;
    logic             w_adv;

    // The whole pipe moves together: it may advance whenever the output slot
    // is empty or is being consumed this cycle.
    assign w_adv        = !r_v[STAGES-1] || bus.out_ready;
    assign bus.in_ready = w_adv;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] w_op_a;
            logic [WIDTH-1:0] w_op_b;
            logic [WIDTH-1:0] w_s_in;
            logic [WIDTH-1:0] w_s_out;
            logic             w_c_in;
            logic             w_v_in;
            logic [SEG:0]     w_sum;

            if (k == 0) begin : g_head
                // B is inverted once at entry so every stage just adds
                assign w_op_a = bus.a;
                assign w_op_b = bus.sub ? ~bus.b : bus.b;
                assign w_c_in = bus.sub ? 1'b1 : bus.cin;
                assign w_v_in = bus.in_valid;
                assign w_s_in = '0;
            end else begin : g_body
                assign w_op_a = r_a[k-1];
                assign w_op_b = r_b[k-1];
                assign w_c_in = r_c[k-1];
                assign w_v_in = r_v[k-1];
                assign w_s_in = r_s[k-1];
            end

            assign w_sum = {1'b0, w_op_a[k*SEG +: SEG]}
                         + {1'b0, w_op_b[k*SEG +: SEG]}
                         + {{SEG{1'b0}}, w_c_in};

            // Merge this stage's sum segment into the partially built result
            always_comb begin
                w_s_out                 = w_s_in;
                w_s_out[k*SEG +: SEG]   = w_sum[SEG-1:0];
            end

            assign w_a_nxt[k] = w_op_a;
            assign w_b_nxt[k] = w_op_b;
            assign w_s_nxt[k] = w_s_out;
            assign w_c_nxt[k] = w_sum[SEG];
            assign w_v_nxt[k] = w_v_in;

            if (k == STAGES - 1) begin : g_tail
                // Same-sign operands producing an opposite-sign result
                assign w_ovf_nxt = (w_op_a[WIDTH-1] == w_op_b[WIDTH-1])
                                && (w_sum[SEG-1] != w_op_a[WIDTH-1]);
            end
        end
    endgenerate

    // Stage registers: cleared by reset, loaded in lock-step on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_nxt[k];
                r_c[k] <= w_c_nxt[k];
                r_a[k] <= w_a_nxt[k];
                r_b[k] <= w_b_nxt[k];
                r_s[k] <= w_s_nxt[k];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.out_valid = r_v[STAGES-1];
    assign bus.s         = r_s[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_addsub
//  Description : Self-checking bench for pipe_addsub. Drives a 64/16 and a
//                32/8 instance in lock-step and compares against an
//                arithmetic reference model with a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_addsub;
    localparam int W0  = 64;
    localparam int S0  = 16;
    localparam int W1  = 32;
    localparam int S1  = 8;
    localparam int LAT = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] a         = '0;
    logic [63:0] b         = '0;
    logic        cin       = 1'b0;
    logic        sub       = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic [65:0] q64 [$];
    logic [65:0] q32 [$];

    pipe_addsub_if #(.WIDTH(W0)) bus64 ();
    pipe_addsub_if #(.WIDTH(W1)) bus32 ();

    assign bus64.in_valid  = in_valid;
    assign bus64.a         = a;
    assign bus64.b         = b;
    assign bus64.cin       = cin;
    assign bus64.sub       = sub;
    assign bus64.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.a         = a[31:0];
    assign bus32.b         = b[31:0];
    assign bus32.cin       = cin;
    assign bus32.sub       = sub;
    assign bus32.out_ready = out_ready;

    pipe_addsub #(.WIDTH(W0), .SEG(S0)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
    pipe_addsub #(.WIDTH(W1), .SEG(S1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed and unsigned integer arithmetic on w-bit values.
    // Returns {ovf, cout, s}.
    function automatic logic [65:0] ref_op(input int w, input logic [63:0] x,
                                           input logic [63:0] y, input logic ci,
                                           input logic sb);
        logic [63:0]        m;
        logic [64:0]        ux, uy, usum;
        logic signed [67:0] sx, sy, r, lim;
        logic               co, ov;
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        ux  = {1'b0, x & m};
        uy  = {1'b0, y & m};
        lim = 68'sd1 <<< (w - 1);
        sx  = $signed({3'b000, ux});
        sy  = $signed({3'b000, uy});
        if (x[w-1]) sx = sx - (lim <<< 1);
        if (y[w-1]) sy = sy - (lim <<< 1);
        if (sb) begin
            r  = sx - sy;
            co = (ux >= uy);
        end else begin
            r    = sx + sy + $signed({67'd0, ci});
            usum = ux + uy + {64'd0, ci};
            co   = usum[w];
        end
        ov = (r >= lim) || (r < -lim);
        return {ov, co, r[63:0] & m};
    endfunction

    function automatic logic [63:0] rand_val();
        case ($urandom_range(0, 9))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h0000_0000_8000_0000;
            5:       return 64'h0000_0000_7FFF_FFFF;
            6:       return {32'h0, 16'h0, 16'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: scoreboard, handshake rule and output stability under stall
    initial begin
        logic        stall64, stall32;
        logic [65:0] prev64, prev32, e;
        stall64 = 1'b0;
        stall32 = 1'b0;
        prev64  = '0;
        prev32  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall64 = 1'b0;
                stall32 = 1'b0;
            end else begin
                chk("in_ready64", bus64.in_ready, !bus64.out_valid || out_ready);
                chk("in_ready32", bus32.in_ready, !bus32.out_valid || out_ready);
                if (stall64)
                    chk("hold64", {bus64.out_valid, bus64.ovf, bus64.cout, bus64.s}, {1'b1, prev64});
                if (stall32)
                    chk("hold32", {bus32.out_valid, bus32.ovf, bus32.cout, 32'h0, bus32.s}, {1'b1, prev32});
                stall64 = bus64.out_valid && !out_ready;
                stall32 = bus32.out_valid && !out_ready;
                prev64  = {bus64.ovf, bus64.cout, bus64.s};
                prev32  = {bus32.ovf, bus32.cout, 32'h0, bus32.s};
                if (bus64.out_valid && out_ready) begin
                    if (q64.size() == 0) chk("spurious64", 1'b0, 1'b1);
                    else begin
                        e = q64.pop_front();
                        chk("res64", {bus64.ovf, bus64.cout, bus64.s}, e);
                    end
                end
                if (bus32.out_valid && out_ready) begin
                    if (q32.size() == 0) chk("spurious32", 1'b0, 1'b1);
                    else begin
                        e = q32.pop_front();
                        chk("res32", {bus32.ovf, bus32.cout, 32'h0, bus32.s}, e);
                    end
                end
                if (in_valid && bus64.in_ready) q64.push_back(ref_op(W0, a, b, cin, sub));
                if (in_valid && bus32.in_ready) q32.push_back(ref_op(W1, a, b, cin, sub));
            end
        end
    end

    // One isolated operation: latency plus literal expected 64-bit result
    task automatic run_one(input logic [63:0] x, input logic [63:0] y, input logic ci,
                           input logic sb, input logic [63:0] es, input logic ec,
                           input logic eo);
        int n;
        bit seen;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) in_valid = 1'b0;
            seen = bus64.out_valid;
        end
        chk("latency64", n, LAT);
        chk("latency32", bus32.out_valid, 1'b1);
        chk("s_dir", bus64.s, es);
        chk("cout_dir", bus64.cout, ec);
        chk("ovf_dir", bus64.ovf, eo);
    endtask

    // Stream of operations; fixed stall window or random valid/ready
    task automatic stream(input int n_ops, input int st0, input int stlen, input bit rnd);
        int sent = 0;
        int t    = 0;
        bit have = 1'b0;
        bit took;
        bit stall;
        while ((sent < n_ops || q64.size() != 0 || q32.size() != 0) && t < 5000) begin
            if (!have && sent < n_ops && (!rnd || $urandom_range(0, 3) != 0)) begin
                a    = rand_val();
                b    = rand_val();
                cin  = 1'($urandom);
                sub  = 1'($urandom);
                have = 1'b1;
            end
            in_valid  = have;
            stall     = !rnd && t >= st0 && t < st0 + stlen;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !stall;
            @(negedge clk);
            took = in_valid && bus64.in_ready;
            if (stall && bus64.out_valid) chk("stall_in_ready", bus64.in_ready, 1'b0);
            @(posedge clk); #1;
            if (took) begin
                have = 1'b0;
                sent++;
            end
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (t >= 5000) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    // Reset with three operations in flight and one parked at the output
    task automatic reset_in_flight();
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rand_val(); b = rand_val(); cin = 1'($urandom); sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", bus64.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", bus64.out_valid, 1'b0);
        chk("rst_s", bus64.s, 64'h0);
        chk("rst_in_ready", bus64.in_ready, 1'b1);
        chk("rst_out_valid32", bus32.out_valid, 1'b0);
        q64.delete();
        q32.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_stale", bus64.out_valid, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", bus64.out_valid, 1'b0);
        chk("reset_s", bus64.s, 64'h0);
        chk("reset_cout_ovf", {bus64.cout, bus64.ovf}, 2'b00);
        chk("reset_in_ready", bus64.in_ready, 1'b1);
        rst = 1'b0;

        run_one(64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0);
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                64'h0, 1'b1, 1'b0);
        run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_one(64'h3, 64'h5, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one(64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);

        stream(8, 5, 3, 1'b0);
        reset_in_flight();
        run_one(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0);
        stream(300, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
